// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stall FSM encoding, register index width, NOP word.
package pipe_pkg;

  localparam int REG_W = 5;

  // All-zero word decodes as sll r0,r0,0; loaded into IF/ID or ID/EX on a flush/bubble.
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_BUSY = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// ID/EX hazard information in, pipeline-register control out, between the
// pipeline datapath (master) and the stall controller (slave).
interface pipe_stall_ctrl_if;
  import pipe_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_mdu_op;
  logic             id_branch_taken;
  logic             ex_wreg;
  logic             ex_m2reg;
  logic [REG_W-1:0] ex_rn;

  // wpcir is a level hold, not a handshake: while it is 0 the PC and IF/ID keep
  // their contents; bubble/flush take effect at the same clock edge they are seen.
  logic             wpcir;
  logic             flush_if_id;
  logic             bubble_id_ex;
  logic             mdu_busy;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_mdu_op, id_branch_taken,
    output ex_wreg, ex_m2reg, ex_rn,
    input  wpcir, flush_if_id, bubble_id_ex, mdu_busy
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_mdu_op, id_branch_taken,
    input  ex_wreg, ex_m2reg, ex_rn,
    output wpcir, flush_if_id, bubble_id_ex, mdu_busy
  );

endinterface

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Combinational load-use hazard check between the ID sources and the EX load
// destination; r0 never hazards. Shared with the forwarding unit.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [REG_W-1:0] ex_rn,
  output logic             lu_hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit    = id_use_rs && (ex_rn == id_rs);
  assign rt_hit    = id_use_rt && (ex_rn == id_rt);
  assign lu_hazard = ex_m2reg && ex_wreg && (ex_rn != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: load-use stalls plus a RUN/BUSY FSM that holds
// ID for MDU_CYCLES-1 cycles per multiply/divide. Optional macro STALL_CNT_EN
// adds a saturating stall_cycles counter output.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_CYCLES = 4,
  parameter int DELAY_SLOT = 1
) (
  input  logic        clock,
  input  logic        resetn,
  pipe_stall_ctrl_if.slave sif
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int          CW       = $clog2(MDU_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = CW'(MDU_CYCLES - 2);
  localparam bit          FLUSH_EN = (DELAY_SLOT == 0);

  pipe_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lu_hazard;
  logic          wpcir;
  logic          flush_if_id;
  logic          bubble_id_ex;

  hazard_detect u_hazard_detect (
    .id_rs     (sif.id_rs),
    .id_rt     (sif.id_rt),
    .id_use_rs (sif.id_use_rs),
    .id_use_rt (sif.id_use_rt),
    .ex_wreg   (sif.ex_wreg),
    .ex_m2reg  (sif.ex_m2reg),
    .ex_rn     (sif.ex_rn),
    .lu_hazard (lu_hazard)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wpcir        = 1'b1;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A load-use stall wins; MDU issue and branch flush retry next cycle.
        if (lu_hazard) begin
          wpcir        = 1'b0;
          bubble_id_ex = 1'b1;
        end else begin
          flush_if_id = sif.id_branch_taken && FLUSH_EN;
          if (sif.id_mdu_op) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_BUSY: begin
        wpcir        = 1'b0;
        bubble_id_ex = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  assign sif.wpcir        = wpcir;
  assign sif.flush_if_id  = flush_if_id;
  assign sif.bubble_id_ex = bubble_id_ex;
  assign sif.mdu_busy     = (state_q == ST_BUSY);

`ifdef STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (!wpcir && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: one instance with DELAY_SLOT=0, one with the default.
module tb_pipe_stall_ctrl;
  import pipe_pkg::*;

  logic clock;
  logic resetn;

  logic [4:0] id_rs, id_rt, ex_rn;
  logic id_use_rs, id_use_rt, id_mdu_op, id_branch_taken, ex_wreg, ex_m2reg;

  int n_assert;
  int n_fail;

  pipe_stall_ctrl_if if0 ();
  pipe_stall_ctrl_if if1 ();

  assign if0.id_rs = id_rs;
  assign if0.id_rt = id_rt;
  assign if0.id_use_rs = id_use_rs;
  assign if0.id_use_rt = id_use_rt;
  assign if0.id_mdu_op = id_mdu_op;
  assign if0.id_branch_taken = id_branch_taken;
  assign if0.ex_wreg = ex_wreg;
  assign if0.ex_m2reg = ex_m2reg;
  assign if0.ex_rn = ex_rn;
  assign if1.id_rs = id_rs;
  assign if1.id_rt = id_rt;
  assign if1.id_use_rs = id_use_rs;
  assign if1.id_use_rt = id_use_rt;
  assign if1.id_mdu_op = id_mdu_op;
  assign if1.id_branch_taken = id_branch_taken;
  assign if1.ex_wreg = ex_wreg;
  assign if1.ex_m2reg = ex_m2reg;
  assign if1.ex_rn = ex_rn;

`ifdef STALL_CNT_EN
  logic [31:0] stall0, stall1;
`endif

  pipe_stall_ctrl #(.MDU_CYCLES(4), .DELAY_SLOT(0)) dut0 (
    .clock  (clock),
    .resetn (resetn),
    .sif    (if0)
`ifdef STALL_CNT_EN
    ,
    .stall_cycles (stall0)
`endif
  );

  pipe_stall_ctrl #(.MDU_CYCLES(4), .DELAY_SLOT(1)) dut1 (
    .clock  (clock),
    .resetn (resetn),
    .sif    (if1)
`ifdef STALL_CNT_EN
    ,
    .stall_cycles (stall1)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- vectors ----------------
  typedef struct {
    string      name;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       mdu;
    logic       br;
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
    logic       exp_wpcir;
    logic       exp_bubble;
    logic       exp_flush0;
  } vec_t;

  vec_t vecs[12];

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_mdu_op = 1'b0; id_branch_taken = 1'b0;
    ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rn = 5'd0;
  endtask

  task automatic apply(input vec_t v);
    id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs; id_use_rt = v.use_rt;
    id_mdu_op = v.mdu; id_branch_taken = v.br;
    ex_wreg = v.wreg; ex_m2reg = v.m2reg; ex_rn = v.rn;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = r; id_rs = r; id_use_rs = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Checks wpcir/bubble/busy on both instances plus each instance's flush.
  task automatic chk_all(input string tag, input logic w, input logic b,
                         input logic busy, input logic f0);
    chk({tag, " wpcir0"},  {31'd0, if0.wpcir},        {31'd0, w});
    chk({tag, " bubble0"}, {31'd0, if0.bubble_id_ex}, {31'd0, b});
    chk({tag, " busy0"},   {31'd0, if0.mdu_busy},     {31'd0, busy});
    chk({tag, " flush0"},  {31'd0, if0.flush_if_id},  {31'd0, f0});
    chk({tag, " wpcir1"},  {31'd0, if1.wpcir},        {31'd0, w});
    chk({tag, " bubble1"}, {31'd0, if1.bubble_id_ex}, {31'd0, b});
    chk({tag, " busy1"},   {31'd0, if1.mdu_busy},     {31'd0, busy});
    chk({tag, " flush1"},  {31'd0, if1.flush_if_id},  32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    n_assert = 0;
    n_fail   = 0;
    //           name        rs  rt  urs urt mdu br  wr  m2r rn  w  b  f0
    vecs[0]  = '{"idle",      0,  0,  0,  0,  0,  0,  0,  0,  0, 1, 0, 0};
    vecs[1]  = '{"lu_rs",     8,  0,  1,  0,  0,  0,  1,  1,  8, 0, 1, 0};
    vecs[2]  = '{"r0",        0,  0,  1,  0,  0,  0,  1,  1,  0, 1, 0, 0};
    vecs[3]  = '{"lu_rt",     3,  9,  1,  1,  0,  0,  1,  1,  9, 0, 1, 0};
    vecs[4]  = '{"rt_unused", 3,  9,  1,  0,  0,  0,  1,  1,  9, 1, 0, 0};
    vecs[5]  = '{"not_load",  8,  0,  1,  0,  0,  0,  1,  0,  8, 1, 0, 0};
    vecs[6]  = '{"no_wreg",   8,  0,  1,  0,  0,  0,  0,  1,  8, 1, 0, 0};
    vecs[7]  = '{"br_taken",  1,  2,  1,  1,  0,  1,  0,  0,  0, 1, 0, 1};
    vecs[8]  = '{"br_lu",     5,  0,  1,  0,  0,  1,  1,  1,  5, 0, 1, 0};
    vecs[9]  = '{"all_three", 5,  0,  1,  0,  1,  1,  1,  1,  5, 0, 1, 0};
    vecs[10] = '{"rs_diff",   7,  6,  1,  1,  0,  0,  1,  1,  8, 1, 0, 0};
    vecs[11] = '{"rs_unused", 8,  0,  0,  0,  0,  0,  1,  1,  8, 1, 0, 0};

    set_idle();
    resetn = 1'b0;
    #1;
    chk_all("reset", 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef STALL_CNT_EN
    chk("reset stall0", stall0, 32'd0);
    chk("reset stall1", stall1, 32'd0);
`endif
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    // Table: none of these leave RUN (mdu only alongside a hazard).
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      apply(vecs[i]);
      #1;
      chk_all(vecs[i].name, vecs[i].exp_wpcir, vecs[i].exp_bubble, 1'b0, vecs[i].exp_flush0);
    end

    // Load-use then drop the load: stall releases next cycle.
    @(negedge clock); set_idle(); set_load_use(5'd8); #1;
    chk_all("lu_seq0", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock); ex_m2reg = 1'b0; #1;
    chk_all("lu_seq1", 1'b1, 1'b0, 1'b0, 1'b0);

    // Priority: hazard defers MDU issue and flush by one cycle.
    @(negedge clock); set_idle(); set_load_use(5'd5);
    id_mdu_op = 1'b1; id_branch_taken = 1'b1; #1;
    chk_all("prio_hold", 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock); ex_m2reg = 1'b0; #1;
    chk_all("prio_issue", 1'b1, 1'b0, 1'b0, 1'b1);
    // BUSY ignores hazard, branch and a held mdu op.
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock); ex_m2reg = 1'b1; #1;
      chk_all($sformatf("busy_a%0d", i), 1'b0, 1'b1, 1'b1, 1'b0);
    end
    // Back-to-back issue on the first RUN cycle.
    @(negedge clock); ex_m2reg = 1'b0; id_branch_taken = 1'b0; #1;
    chk_all("b2b_issue", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock); id_mdu_op = 1'b0; #1;
      chk_all($sformatf("busy_b%0d", i), 1'b0, 1'b1, 1'b1, 1'b0);
    end
    @(negedge clock); #1;
    chk_all("b2b_done", 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset during BUSY: returns to RUN immediately.
    @(negedge clock); set_idle(); id_mdu_op = 1'b1; #1;
    chk_all("rst_issue", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock); id_mdu_op = 1'b0; #1;
    chk_all("rst_busy", 1'b0, 1'b1, 1'b1, 1'b0);
    #1 resetn = 1'b0;
    #1;
    chk_all("rst_async", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock); resetn = 1'b1; #1;
    chk_all("rst_rel0", 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clock); #1;
    chk_all("rst_rel1", 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef STALL_CNT_EN
    chk("cnt_clr0", stall0, 32'd0);
    // One load-use stall plus one MDU op (3 stall cycles).
    @(negedge clock); set_load_use(5'd8); #1;
    @(negedge clock); set_idle(); id_mdu_op = 1'b1; #1;
    @(negedge clock); id_mdu_op = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("stall_cnt0", stall0, 32'd4);
    chk("stall_cnt1", stall1, 32'd4);
    @(negedge clock); #1;
    chk("stall_hold0", stall0, 32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
